// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one RAM port among NREQ cache requesters, round-robin, one transaction in flight.
// Latency : grant registered one cycle after request; hit/err combinational with ram_state in BUSY;
//           one RELEASE cycle after every completed transaction (3-cycle minimum turnaround).
// Backpr. : requesters hold ren/wen/addr/store until their hit/err pulse; RAM stalls via ram_state BUSY.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   req_ren/req_wen      per-requester read/write request (both high = write)
//   req_addr/req_store   per-requester word address / write data, slice i = [32*i+31:32*i]
//   req_hit/req_err      one-cycle completion / error pulse to the owner only
//   req_load             read data, broadcast of ram_load (valid with req_hit)
//   ram_ren/ram_wen      RAM enables, only driven in BUSY while the owner still requests
//   ram_addr/ram_store   owner's address / write data, zero outside BUSY
//   ram_load/ram_state   RAM read data / status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//   owner                current or last granted requester index (debug)
module mem_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WW     = $clog2(TIMEOUT) + 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_store,
  output logic [NREQ-1:0]      req_hit,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          req_load,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_store,
  input  logic [31:0]          ram_load,
  input  logic [1:0]           ram_state,
  output logic [OW-1:0]        owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [WW-1:0]   wdog_q;

  logic [NREQ-1:0] req_any;
  logic            grant_vld;
  logic [OW-1:0]   grant_idx;

  logic            in_busy;
  logic            own_ren;
  logic            own_wen;
  logic            own_act;
  logic            done_hit;
  logic            done_err;
  logic            abort;
  logic            wdog_expired;

  assign req_any = req_ren | req_wen;

  // Round-robin pick: first requester scanning last+1 .. last+NREQ (mod NREQ).
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!grant_vld && req_any[idx]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  assign in_busy      = (state_q == S_BUSY);
  assign own_ren      = req_ren[owner_q];
  assign own_wen      = req_wen[owner_q];
  // The RAM sees the owner only while it still holds a request, so an abort
  // drops every ram_* signal in the same cycle the request disappears.
  assign own_act      = in_busy & (own_ren | own_wen);
  assign wdog_expired = (wdog_q == WW'(TIMEOUT - 1));

  // Completion priority: ACCESS > ERROR > watchdog > abort.
  assign done_hit = in_busy & (ram_state == RAM_ACCESS);
  assign done_err = in_busy & ~done_hit & ((ram_state == RAM_ERROR) | wdog_expired);
  assign abort    = in_busy & ~done_hit & ~done_err & ~(own_ren | own_wen);

  // A write wins when ren and wen are both asserted.
  assign ram_ren   = own_act & own_ren & ~own_wen;
  assign ram_wen   = own_act & own_wen;
  assign ram_addr  = own_act ? req_addr[32*owner_q +: 32]  : 32'd0;
  assign ram_store = own_act ? req_store[32*owner_q +: 32] : 32'd0;
  assign req_load  = ram_load;
  assign owner     = owner_q;

  always_comb begin
    req_hit = '0;
    req_err = '0;
    if (done_hit) req_hit[owner_q] = 1'b1;
    if (done_err) req_err[owner_q] = 1'b1;
  end

  // Last-granted pointer starts at NREQ-1 so requester 0 wins the first scan.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      wdog_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            owner_q <= grant_idx;
            wdog_q  <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Saturating watchdog: it can never wrap back into a false "fresh" count.
          if (wdog_q != '1) wdog_q <= wdog_q + 1'b1;
          if (done_hit || done_err) begin
            last_q  <= owner_q;
            state_q <= S_RELEASE;
          end else if (abort) begin
            // Nothing was completed, so there is no stale request to shield.
            last_q  <= owner_q;
            state_q <= S_IDLE;
          end
        end
        S_RELEASE: begin
          // One dead cycle lets the finished requester drop its request
          // before the next scan, so it is never granted twice.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
